ram_wr_sched: RTL and testbench



---
 rtl/ram_wr_sched_if.sv | 26 ++
 rtl/ram_wr_sched.sv | 131 +++++++++++++
 tb/tb_ram_wr_sched.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_wr_sched_if.sv
// Requester-side write handshake bundle for ram_wr_sched.
// Slices are packed: requester i owns bit i / slice i of each vector.
interface ram_wr_sched_if #(
    parameter int AW   = 11,
    parameter int DW   = 32,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/ram_wr_sched.sv
// Round-robin write-port scheduler with a zero-fill clear sweep
// in front of the single write port of ram_32R1W.
module ram_wr_sched #(
    parameter int BLOCKSIZE = 10,
    parameter int DW        = 32,
    parameter int NREQ      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    ram_wr_sched_if.slave             req,
    input  logic                      clr_start,
    output logic                      clr_busy,
    output logic                      clr_done,
    output logic [BLOCKSIZE:0]        w_addr,
    output logic [DW-1:0]             w_din,
    output logic                      w_enb,
    output logic [$clog2(NREQ)-1:0]   grant_id
);
    localparam int AW    = BLOCKSIZE + 1;
    localparam int IW    = $clog2(NREQ);

    localparam logic [0:0] ST_CLR = 1'b0;
    localparam logic [0:0] ST_ARB = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          w_enb_q, w_enb_d;
    logic [AW-1:0] w_addr_q, w_addr_d;
    logic [DW-1:0] w_din_q, w_din_d;
    logic [IW-1:0] grant_q, grant_d;
    logic          clr_done_q, clr_done_d;

    logic          hit;
    logic          hs;
    logic [IW-1:0] gnt;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // First valid requester at or after ptr, wrapping modulo NREQ.
    always_comb begin : arb
        int idx;
        hit = 1'b0;
        gnt = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!hit && req.req_valid[idx]) begin
                hit = 1'b1;
                gnt = IW'(idx);
            end
        end
    end

    assign hs       = (state_q == ST_ARB) && hit;
    assign sel_addr = req.req_addr[int'(gnt)*AW +: AW];
    assign sel_data = req.req_data[int'(gnt)*DW +: DW];

    always_comb begin : ready_dec
        req.req_ready = '0;
        if (hs) req.req_ready[gnt] = 1'b1;
    end

    always_comb begin : nxt
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        w_enb_d    = 1'b0;
        w_addr_d   = w_addr_q;
        w_din_d    = w_din_q;
        grant_d    = grant_q;
        clr_done_d = 1'b0;
        unique case (state_q)
            ST_CLR: begin
                w_enb_d  = 1'b1;
                w_addr_d = cnt_q;
                w_din_d  = '0;
                grant_d  = '0;
                cnt_d    = cnt_q + 1'b1;
                if (&cnt_q) begin
                    clr_done_d = 1'b1;
                    state_d    = ST_ARB;
                end
            end
            ST_ARB: begin
                if (hs) begin
                    w_enb_d  = 1'b1;
                    w_addr_d = sel_addr;
                    w_din_d  = sel_data;
                    grant_d  = gnt;
                    ptr_d    = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
                end
                // A same-cycle grant still lands; the sweep follows it.
                if (clr_start) begin
                    state_d = ST_CLR;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_CLR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_CLR;
            cnt_q      <= '0;
            ptr_q      <= '0;
            w_enb_q    <= 1'b0;
            w_addr_q   <= '0;
            w_din_q    <= '0;
            grant_q    <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            w_enb_q    <= w_enb_d;
            w_addr_q   <= w_addr_d;
            w_din_q    <= w_din_d;
            grant_q    <= grant_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign clr_busy = (state_q == ST_CLR);
    assign clr_done = clr_done_q;
    assign w_enb    = w_enb_q;
    assign w_addr   = w_addr_q;
    assign w_din    = w_din_q;
    assign grant_id = grant_q;
endmodule

// File: tb/tb_ram_wr_sched.sv
// Scoreboard bench for ram_wr_sched: a cycle-level reference model
// queues the expected write-port state, a monitor pops and compares.
module tb_ram_wr_sched;
    localparam int BLOCKSIZE = 10;
    localparam int AW        = BLOCKSIZE + 1;
    localparam int DW        = 32;
    localparam int NREQ      = 4;
    localparam int IW        = 2;
    localparam int DEPTH     = 2048;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr_start = 1'b0;
    logic          clr_busy, clr_done, w_enb;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_din;
    logic [IW-1:0] grant_id;

    ram_wr_sched_if #(.AW(AW), .DW(DW), .NREQ(NREQ)) bus ();

    ram_wr_sched #(.BLOCKSIZE(BLOCKSIZE), .DW(DW), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (bus),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .w_addr    (w_addr),
        .w_din     (w_din),
        .w_enb     (w_enb),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          enb;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [IW-1:0] gid;
        logic          done;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: clearing flag, sweep position, rr pointer, held bus.
    bit            m_clr  = 1'b1;
    int            m_cnt  = 0;
    int            m_ptr  = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_din  = '0;
    logic [IW-1:0] m_gid  = '0;
    logic [DW-1:0] ref_mem[DEPTH];
    logic [DW-1:0] dut_mem[DEPTH];
    int            last_g;

    bit            pend[NREQ];
    logic [AW-1:0] p_addr[NREQ];
    logic [DW-1:0] p_data[NREQ];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]        = v;
        bus.req_addr[i*AW +: AW] = a;
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic idle_inputs();
        clr_start = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);
    endtask

    // Called between edges with inputs applied; models the next edge.
    task automatic step();
        exp_t            e;
        int              g;
        int              i;
        logic [NREQ-1:0] er;
        #1;
        er = '0;
        g  = -1;
        chk("clr_busy", clr_busy, m_clr);
        if (m_clr) begin
            e.enb  = 1'b1;
            e.addr = AW'(m_cnt);
            e.din  = '0;
            e.gid  = '0;
            e.done = (m_cnt == DEPTH - 1);
            m_addr = e.addr;
            m_din  = '0;
            m_gid  = '0;
            ref_mem[m_cnt] = '0;
            m_cnt++;
            if (m_cnt == DEPTH) begin
                m_cnt = 0;
                m_clr = 1'b0;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (g < 0 && bus.req_valid[i]) g = i;
            end
            e.done = 1'b0;
            e.enb  = 1'b0;
            if (g >= 0) begin
                er[g]  = 1'b1;
                e.enb  = 1'b1;
                m_addr = bus.req_addr[g*AW +: AW];
                m_din  = bus.req_data[g*DW +: DW];
                m_gid  = IW'(g);
                ref_mem[m_addr] = m_din;
                m_ptr  = (g + 1) % NREQ;
            end
            e.addr = m_addr;
            e.din  = m_din;
            e.gid  = m_gid;
            if (clr_start) begin
                m_clr = 1'b1;
                m_cnt = 0;
            end
        end
        chk("req_ready", bus.req_ready, er);
        sb.push_back(e);
        last_g = g;
        @(posedge clk);
        #2;
    endtask

    task automatic readback(input logic [AW-1:0] a);
        chk("readback", dut_mem[a], ref_mem[a]);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("w_enb", w_enb, e.enb);
                chk("w_addr", w_addr, e.addr);
                chk("w_din", w_din, e.din);
                chk("grant_id", grant_id, e.gid);
                chk("clr_done", clr_done, e.done);
                if (w_enb) dut_mem[w_addr] = w_din;
            end
        end
    end

    initial begin : driver
        idle_inputs();
        for (int a = 0; a < DEPTH; a++) begin
            ref_mem[a] = 'x;
            dut_mem[a] = 'x;
        end
        repeat (3) @(posedge clk);
        #2;
        chk("rst_w_enb", w_enb, 0);
        chk("rst_w_addr", w_addr, 0);
        chk("rst_w_din", w_din, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_busy", clr_busy, 1);

        // Post-reset sweep with idle requesters.
        rst = 1'b1;
        repeat (DEPTH) step();

        // Requester 2 alone.
        set_req(2, 1'b1, 11'h155, 32'hDEADBEEF);
        step();
        idle_inputs();
        step();

        // Move ptr to 0, then all four continuously.
        set_req(3, 1'b1, 11'h300, 32'h33333333);
        step();
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, AW'(16 + i), 32'hA0000000 + i);
        repeat (5) step();
        idle_inputs();
        step();
        for (int i = 0; i < NREQ; i++) readback(AW'(16 + i));
        readback(11'h155);
        readback(11'h300);

        // ptr lands on 3; requesters 1 and 3 compete; then a withdrawal.
        set_req(2, 1'b1, 11'h042, 32'h22222222);
        step();
        idle_inputs();
        set_req(1, 1'b1, 11'h101, 32'h11110001);
        set_req(3, 1'b1, 11'h303, 32'h33330003);
        step();
        set_req(3, 1'b0, '0, '0);
        step();
        idle_inputs();
        set_req(0, 1'b1, 11'h0AA, 32'h0A0A0A0A);
        set_req(2, 1'b1, 11'h2BB, 32'h2B2B2B2B);
        step();
        idle_inputs();
        step();
        step();

        // Randomised traffic with legal withdrawals.
        for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom % 3 == 0)) begin
                    pend[i]   = 1'b1;
                    p_addr[i] = AW'($urandom);
                    p_data[i] = $urandom;
                end else if (pend[i] && ($urandom % 10 == 0)) begin
                    pend[i] = 1'b0;
                end
                set_req(i, pend[i], p_addr[i], p_data[i]);
            end
            step();
            if (last_g >= 0) pend[last_g] = 1'b0;
        end
        idle_inputs();
        step();
        for (int a = 0; a < DEPTH; a += 7) readback(AW'(a));

        // clr_start with a same-cycle grant; requesters wait out the sweep.
        set_req(0, 1'b1, 11'h007, 32'h00001234);
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < NREQ; i++)
            set_req(i, 1'b1, AW'(32 + i), 32'hC0DE0000 + i);
        repeat (DEPTH) step();
        idle_inputs();
        step();
        step();
        readback(11'h007);
        readback(11'h155);

        // Reset in the middle of a sweep.
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (1001) step();
        rst = 1'b0;
        #1;
        chk("mid_rst_w_enb", w_enb, 0);
        chk("mid_rst_w_addr", w_addr, 0);
        chk("mid_rst_busy", clr_busy, 1);
        chk("mid_rst_ready", bus.req_ready, 0);
        chk("mid_rst_sb_empty", sb.size(), 0);
        sb.delete();
        m_clr  = 1'b1;
        m_cnt  = 0;
        m_ptr  = 0;
        m_addr = '0;
        m_din  = '0;
        m_gid  = '0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (DEPTH) step();
        set_req(1, 1'b1, 11'h011, 32'h51515151);
        set_req(3, 1'b1, 11'h033, 32'h53535353);
        step();
        step();
        idle_inputs();
        step();
        step();
        chk("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
